// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: big-endian sub-word loads/stores over a word-wide bus.
// Optional one-entry posted write buffer enabled by defining DMEM_PORT_WRITE_BUF_EN.
module dmem_port_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        proc_rd,
    input  logic        proc_we,
    input  logic [0:31] proc_addr,
    input  logic        proc_byte,
    input  logic        proc_half_word,
    input  logic        proc_sign_extend,
    input  logic [0:31] proc_wdata,
    output logic [0:31] proc_rdata,
    output logic        proc_stall,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:3]  mem_be,
    output logic [0:31] mem_wdata,
    input  logic        mem_ack,
    input  logic [0:31] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [1:0]  off;
    logic        misaligned;
    logic [0:3]  be_next;
    logic [0:31] wdata_next;
    logic [1:0]  ld_off;
    logic        ld_byte;
    logic        ld_half;
    logic        ld_sext;
    logic        wbuf_busy;
    logic        buf_take;

    assign off = proc_addr[30:31];

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = proc_wdata;
        if (proc_byte) begin
            be_next    = 4'b1000 >> off;
            wdata_next = {4{proc_wdata[24:31]}};
        end else if (proc_half_word) begin
            misaligned = off[0];
            be_next    = off[1] ? 4'b0011 : 4'b1100;
            wdata_next = {2{proc_wdata[16:31]}};
        end else begin
            misaligned = (off != 2'b00);
        end
    end

    function automatic logic [0:31] extract(input logic [0:31] d, input logic [1:0] o,
                                            input logic bsel, input logic hsel,
                                            input logic sext);
        logic [0:7]  b;
        logic [0:15] h;
        logic [0:31] r;
        case (o)
            2'd0:    b = d[0:7];
            2'd1:    b = d[8:15];
            2'd2:    b = d[16:23];
            default: b = d[24:31];
        endcase
        h = o[1] ? d[16:31] : d[0:15];
        if (bsel)
            r = {{24{sext & b[0]}}, b};
        else if (hsel)
            r = {{16{sext & h[0]}}, h};
        else
            r = d;
        return r;
    endfunction

`ifdef DMEM_PORT_WRITE_BUF_EN
    assign buf_take = (state == IDLE) && proc_we && !misaligned;
`else
    assign buf_take  = 1'b0;
    assign wbuf_busy = 1'b0;
`endif

    always_comb begin
        proc_stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    proc_stall = (proc_rd || proc_we) && !buf_take;
                REQ:     proc_stall = wbuf_busy ? (proc_rd || proc_we) : 1'b1;
                default: proc_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            proc_rdata <= '0;
            misalign   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            ld_off     <= '0;
            ld_byte    <= 1'b0;
            ld_half    <= 1'b0;
            ld_sext    <= 1'b0;
`ifdef DMEM_PORT_WRITE_BUF_EN
            wbuf_busy  <= 1'b0;
`endif
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (proc_rd || proc_we) begin
                        if (misaligned) begin
                            state    <= DONE;
                            misalign <= 1'b1;
                            if (!proc_we)
                                proc_rdata <= '0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= proc_we;
                            mem_addr  <= {proc_addr[0:29], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            ld_off    <= off;
                            ld_byte   <= proc_byte;
                            ld_half   <= proc_half_word;
                            ld_sext   <= proc_sign_extend;
`ifdef DMEM_PORT_WRITE_BUF_EN
                            wbuf_busy <= buf_take;
`endif
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            proc_rdata <= extract(mem_rdata, ld_off, ld_byte, ld_half, ld_sext);
                        // A background drain has no waiting processor, so skip DONE.
                        state <= wbuf_busy ? IDLE : DONE;
`ifdef DMEM_PORT_WRITE_BUF_EN
                        wbuf_busy <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed self-checking bench for dmem_port_ctrl; expected values computed by hand.
module tb_dmem_port_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_rd, proc_we, proc_byte, proc_half_word, proc_sign_extend;
    logic [0:31] proc_addr, proc_wdata, proc_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        proc_stall, misalign, mem_req, mem_we, mem_ack;
    logic [0:3]  mem_be;
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned stall_cnt;

    always #5 clock = ~clock;

    dmem_port_ctrl dut (
        .clock(clock), .reset(reset),
        .proc_rd(proc_rd), .proc_we(proc_we), .proc_addr(proc_addr),
        .proc_byte(proc_byte), .proc_half_word(proc_half_word),
        .proc_sign_extend(proc_sign_extend), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setup(input logic rd, input logic we, input logic [31:0] addr,
                         input logic b, input logic h, input logic s, input logic [31:0] wd);
        proc_rd = rd; proc_we = we; proc_addr = addr; proc_byte = b;
        proc_half_word = h; proc_sign_extend = s; proc_wdata = wd;
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        setup(1, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_stall", proc_stall, 0);
        chk("rst_rdata", proc_rdata, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_misalign", misalign, 0);
        proc_rd = 1'b0; reset = 1'b0;
        tick();

        // lbu 0x103, ack in the third REQ cycle
        stall_cnt = 0;
        setup(1, 0, 32'h103, 1, 0, 0, 0); #1;
        chk("lbu_c0_stall", proc_stall, 1);
        chk("lbu_c0_req", mem_req, 0);
        stall_cnt += proc_stall;
        tick(); #1;
        stall_cnt += proc_stall;
        chk("lbu_c1_req", mem_req, 1);
        chk("lbu_c1_addr", mem_addr, 32'h100);
        chk("lbu_c1_we", mem_we, 0);
        tick(); #1;
        stall_cnt += proc_stall;
        chk("lbu_c2_req", mem_req, 1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h1122_33F4; #1;
        stall_cnt += proc_stall;
        tick(); mem_ack = 1'b0; #1;
        stall_cnt += proc_stall;
        chk("lbu_done_stall", proc_stall, 0);
        chk("lbu_rdata", proc_rdata, 32'h0000_00F4);
        chk("lbu_done_req", mem_req, 0);
        proc_rd = 1'b0;
        tick(); #1;
        chk("lbu_stall_cycles", stall_cnt, 4);
        chk("lbu_hold", proc_rdata, 32'h0000_00F4);

        // lh 0x102 sign-extended, minimum latency
        setup(1, 0, 32'h102, 0, 1, 1, 0); #1;
        chk("lh_c0_stall", proc_stall, 1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_8001; #1;
        chk("lh_c1_req", mem_req, 1);
        chk("lh_c1_be", mem_be, 4'b0011);
        tick(); mem_ack = 1'b0; #1;
        chk("lh_done_stall", proc_stall, 0);
        chk("lh_rdata", proc_rdata, 32'hFFFF_8001);
        proc_rd = 1'b0; tick();

        // lb 0x100 sign-extended
        setup(1, 0, 32'h100, 1, 0, 1, 0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
        tick(); mem_ack = 1'b0; #1;
        chk("lb_rdata", proc_rdata, 32'hFFFF_FF80);
        proc_rd = 1'b0; tick();

        // lw 0x104 passes through
        setup(1, 0, 32'h104, 0, 0, 1, 0);
        tick(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick(); mem_ack = 1'b0; #1;
        chk("lw_rdata", proc_rdata, 32'hDEAD_BEEF);
        proc_rd = 1'b0; tick();

        // sb 0xAB at 0x201
        setup(0, 1, 32'h201, 1, 0, 0, 32'h0000_00AB); #1;
`ifdef DMEM_PORT_WRITE_BUF_EN
        chk("sb_c0_stall", proc_stall, 0);
`else
        chk("sb_c0_stall", proc_stall, 1);
`endif
        tick(); #1;
        chk("sb_req", mem_req, 1);
        chk("sb_we", mem_we, 1);
        chk("sb_addr", mem_addr, 32'h200);
        chk("sb_be", mem_be, 4'b0100);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; proc_we = 1'b0; #1;
        chk("sb_after_req", mem_req, 0);
        chk("sb_rdata_kept", proc_rdata, 32'hDEAD_BEEF);
        tick();

        // sh 0x1234 at 0x202, fields stable over two REQ cycles
        setup(0, 1, 32'h202, 0, 1, 0, 32'h0000_1234);
        tick(); proc_we = 1'b0; #1;
        tick(); #1;
        chk("sh_req", mem_req, 1);
        chk("sh_be", mem_be, 4'b0011);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("sh_addr", mem_addr, 32'h200);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; #1;
        chk("sh_after_req", mem_req, 0);
        tick();

        // misaligned lw 0x106
        setup(1, 0, 32'h106, 0, 0, 0, 0); #1;
        chk("mis_c0_stall", proc_stall, 1);
        tick(); #1;
        chk("mis_req", mem_req, 0);
        chk("mis_pulse", misalign, 1);
        chk("mis_rdata", proc_rdata, 0);
        chk("mis_stall", proc_stall, 0);
        proc_rd = 1'b0;
        tick(); #1;
        chk("mis_pulse_end", misalign, 0);
        chk("mis_no_req", mem_req, 0);

        // reset while REQ is waiting for ack
        setup(1, 0, 32'h300, 0, 0, 0, 0);
        tick(); #1;
        chk("rreq_req", mem_req, 1);
        reset = 1'b1; #1;
        chk("rreq_stall_in_reset", proc_stall, 0);
        tick(); #1;
        chk("rreq_req_dropped", mem_req, 0);
        reset = 1'b0; proc_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick(); mem_ack = 1'b0; #1;
        chk("rreq_ack_ignored_req", mem_req, 0);
        chk("rreq_ack_ignored_rdata", proc_rdata, 0);
        chk("rreq_idle_stall", proc_stall, 0);
        setup(1, 0, 32'h400, 0, 0, 0, 0); #1;
        chk("rreq_new_stall", proc_stall, 1);
        tick(); #1;
        chk("rreq_new_req", mem_req, 1);
        chk("rreq_new_addr", mem_addr, 32'h400);
        mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick(); mem_ack = 1'b0; #1;
        chk("rreq_new_rdata", proc_rdata, 32'h55AA_55AA);
        proc_rd = 1'b0; tick();

`ifdef DMEM_PORT_WRITE_BUF_EN
        // posted sw followed immediately by lw
        setup(0, 1, 32'h500, 0, 0, 0, 32'hCAFE_F00D); #1;
        chk("wb_sw_stall", proc_stall, 0);
        tick();
        setup(1, 0, 32'h504, 0, 0, 0, 0); #1;
        chk("wb_drain_req", mem_req, 1);
        chk("wb_drain_we", mem_we, 1);
        chk("wb_drain_addr", mem_addr, 32'h500);
        chk("wb_drain_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("wb_drain_be", mem_be, 4'b1111);
        chk("wb_lw_stall_busy", proc_stall, 1);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; #1;
        chk("wb_idle_req", mem_req, 0);
        chk("wb_lw_stall_idle", proc_stall, 1);
        tick(); #1;
        chk("wb_lw_req", mem_req, 1);
        chk("wb_lw_we", mem_we, 0);
        chk("wb_lw_addr", mem_addr, 32'h504);
        chk("wb_lw_stall_req", proc_stall, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
        tick(); mem_ack = 1'b0; #1;
        chk("wb_lw_done_stall", proc_stall, 0);
        chk("wb_lw_rdata", proc_rdata, 32'h0102_0304);
        proc_rd = 1'b0; tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_port_ctrl.md
DMEM_PORT_CTRL -- requirements
Module: dmem_port_ctrl

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port proc_rd, input, 1 bit: processor load request.
REQ-004 The block SHALL have port proc_we, input, 1 bit: processor store request.
REQ-005 The block SHALL have port proc_addr, input, [0:31]: byte address; bit 31 is the LSB.
REQ-006 The block SHALL have port proc_byte, input, 1 bit: byte access.
REQ-007 The block SHALL have port proc_half_word, input, 1 bit: halfword access.
REQ-008 The block SHALL have port proc_sign_extend, input, 1 bit: sign-extend loaded sub-word.
REQ-009 The block SHALL have port proc_wdata, input, [0:31]: store data, right-justified in bits [24:31] or [16:31].
REQ-010 The block SHALL have port proc_rdata, output, [0:31]: load result.
REQ-011 The block SHALL have port proc_stall, output, 1 bit: freeze processor pipeline.
REQ-012 The block SHALL have port misalign, output, 1 bit: one-cycle misaligned-access pulse.
REQ-013 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, [0:31], bits 30:31 always 0), mem_be (output, [0:3]), mem_wdata (output, [0:31]), mem_ack (input, 1) and mem_rdata (input, [0:31]).

Function
REQ-014 Byte lanes SHALL be big-endian: address offset k maps to mem_be[k] and data bits [8k:8k+7].
REQ-015 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-016 In IDLE with proc_rd or proc_we high, the block SHALL drive proc_stall=1 combinationally and capture address, size, data and direction, then enter REQ; with proc_rd and proc_we both high, the access SHALL be treated as a store.
REQ-017 In REQ, the block SHALL hold mem_req=1 with all mem_* fields stable until the cycle mem_ack=1, then enter DONE; proc_stall SHALL stay 1.
REQ-018 On a load, the block SHALL register mem_rdata on mem_ack, extract the addressed lane(s) right-justified, then sign-extend if proc_sign_extend=1 or zero-extend if it is 0; a word load SHALL pass through unchanged.
REQ-019 On a store, the block SHALL replicate the byte or halfword to every matching lane of mem_wdata, and mem_be SHALL select only the addressed lanes (word: 1111).
REQ-020 DONE SHALL last exactly one cycle, with proc_stall=0 and proc_rdata valid; proc_rdata SHALL hold until the next load completes, and the FSM SHALL then return to IDLE.
REQ-021 Minimum latency SHALL be: access seen in cycle 0, mem_req first high in cycle 1, ack in cycle 1 gives DONE in cycle 2, so the stall covers 2 cycles.
REQ-022 A halfword with addr[31]=1, or a word with addr[30:31]!=00, SHALL go IDLE->DONE without a mem_req, pulse misalign in DONE, and return proc_rdata=0.
REQ-023 The block SHALL ignore mem_ack outside REQ.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL enter IDLE and clear proc_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, misalign and the write buffer.
REQ-025 Reset during REQ SHALL drop mem_req on the next cycle, and the block SHALL discard the in-flight access.
REQ-026 proc_stall SHALL be 0 while reset is high.

Configuration
REQ-027 With macro DMEM_PORT_WRITE_BUF_EN defined, an aligned store in IDLE SHALL be captured into a one-entry buffer with proc_stall=0 that cycle, and the buffer SHALL drain through REQ in the background.
REQ-028 With DMEM_PORT_WRITE_BUF_EN defined, any new access while the buffer is busy SHALL stall until the drain acks, and SHALL then be handled from IDLE.
REQ-029 Without DMEM_PORT_WRITE_BUF_EN, stores SHALL stall exactly like loads (REQ-016..020).

Verification
REQ-030 The bench SHALL cover: lbu at addr 0x103 with mem_rdata 0x1122_33F4 and ack after 3 cycles -> proc_rdata=0x0000_00F4, proc_stall high 4 cycles.
REQ-031 The bench SHALL cover: lh at addr 0x102 with mem_rdata 0x0000_8001 -> proc_rdata=0xFFFF_8001.
REQ-032 The bench SHALL cover: sb 0xAB at addr 0x201 -> mem_addr=0x200, mem_be=0100, mem_wdata=0xABAB_ABAB, mem_we=1.
REQ-033 The bench SHALL cover: lw at addr 0x106 -> no mem_req, misalign pulsed 1 cycle, proc_rdata=0.
REQ-034 The bench SHALL cover: reset asserted in REQ before ack -> mem_req=0 next cycle, state IDLE, later ack ignored.
REQ-035 The bench SHALL cover, with DMEM_PORT_WRITE_BUF_EN: sw then lw back-to-back -> the sw does not stall, and the lw stalls until the sw acks plus its own access.
